ita_hwpe_addressgen: RTL and testbench

ITA_HWPE_ADDRESSGEN -- requirements
Module: ita_hwpe_addressgen

---
 rtl/ita_hwpe_addressgen.sv | 169 ++++++++++++++++
 tb/tb_ita_hwpe_addressgen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ita_hwpe_addressgen.sv
// Strided 1D/2D/3D address generator for an HWPE streamer; valid/ready address output.
// First address the cycle after start; addr_o holds while addr_ready_i is low.
module ita_hwpe_addressgen #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] tot_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [AW-1:0] d2_stride_i,
  input  logic [CW-1:0] d0_len_i,
  input  logic [CW-1:0] d1_len_i,
  input  logic [1:0]    dim_enable_1h_i,
  output logic          ready_start_o,
  output logic          done_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, row_q, row_d, plane_q, plane_d;
  logic [CW-1:0] cnt_q, cnt_d, i0_q, i0_d, i1_q, i1_d;
  logic [CW-1:0] tot_q, l0_q, l1_q;
  logic [AW-1:0] s0_q, s1_q, s2_q;
  // dim_q[0]: multi-dimensional (2D or 3D), dim_q[1]: 3D
  logic [1:0]    dim_q;
  logic          start_accept, last_xfer;
  logic [AW-1:0] row_next, plane_next;

  assign start_accept = (state_q == IDLE) && req_start_i && !clear_i && (tot_len_i != '0);
  assign last_xfer    = (cnt_q == tot_q - CNT_ONE);
  assign row_next     = row_q + s1_q;
  assign plane_next   = plane_q + s2_q;
  assign addr_o       = addr_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    row_d         = row_q;
    plane_d       = plane_q;
    cnt_d         = cnt_q;
    i0_d          = i0_q;
    i1_d          = i1_q;
    ready_start_o = 1'b0;
    addr_valid_o  = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        ready_start_o = 1'b1;
        if (req_start_i) begin
          if (tot_len_i != '0) begin
            state_d = RUN;
            addr_d  = base_addr_i;
            row_d   = base_addr_i;
            plane_d = base_addr_i;
            cnt_d   = '0;
            i0_d    = '0;
            i1_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        addr_valid_o = 1'b1;
        if (addr_ready_i) begin
          if (last_xfer) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (!dim_q[0]) begin
              addr_d = addr_q + s0_q;
            end else if (i0_q != l0_q - CNT_ONE) begin
              i0_d   = i0_q + CNT_ONE;
              addr_d = addr_q + s0_q;
            end else begin
              i0_d = '0;
              // Row wrap: in 2D the row index is unbounded, so only 3D checks the plane edge
              if (!dim_q[1] || (i1_q != l1_q - CNT_ONE)) begin
                if (dim_q[1]) i1_d = i1_q + CNT_ONE;
                row_d  = row_next;
                addr_d = row_next;
              end else begin
                i1_d    = '0;
                plane_d = plane_next;
                row_d   = plane_next;
                addr_d  = plane_next;
              end
            end
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      addr_d  = '0;
      row_d   = '0;
      plane_d = '0;
      cnt_d   = '0;
      i0_d    = '0;
      i1_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
    end
  end

  // Config is captured once per job; zero lengths are promoted to 1 here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tot_q <= '0;
      l0_q  <= '0;
      l1_q  <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      dim_q <= '0;
    end else if (clear_i) begin
      tot_q <= '0;
      l0_q  <= '0;
      l1_q  <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      dim_q <= '0;
    end else if (start_accept) begin
      tot_q <= tot_len_i;
      l0_q  <= (d0_len_i == '0) ? CNT_ONE : d0_len_i;
      l1_q  <= (d1_len_i == '0) ? CNT_ONE : d1_len_i;
      s0_q  <= d0_stride_i;
      s1_q  <= d1_stride_i;
      s2_q  <= d2_stride_i;
      dim_q <= {(dim_enable_1h_i == 2'b11), (dim_enable_1h_i != 2'b00)};
    end
  end

endmodule

// File: tb/tb_ita_hwpe_addressgen.sv
// Self-checking bench for ita_hwpe_addressgen: directed vectors, corner sequences, random jobs.
module tb_ita_hwpe_addressgen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        req_start_i = 1'b0;
  logic [31:0] base_addr_i = '0, tot_len_i = '0;
  logic [31:0] d0_stride_i = '0, d1_stride_i = '0, d2_stride_i = '0;
  logic [31:0] d0_len_i = '0, d1_len_i = '0;
  logic [1:0]  dim_enable_1h_i = '0;
  logic        ready_start_o, done_o, addr_valid_o;
  logic        addr_ready_i = 1'b0;
  logic [31:0] addr_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ita_hwpe_addressgen dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_start_i(req_start_i),
    .base_addr_i(base_addr_i), .tot_len_i(tot_len_i),
    .d0_stride_i(d0_stride_i), .d1_stride_i(d1_stride_i), .d2_stride_i(d2_stride_i),
    .d0_len_i(d0_len_i), .d1_len_i(d1_len_i), .dim_enable_1h_i(dim_enable_1h_i),
    .ready_start_o(ready_start_o), .done_o(done_o), .addr_o(addr_o),
    .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] base, tot, s0, s1, s2, l0, l1;
    logic [1:0]  dim;
    logic [31:0] exp[8];
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address of transfer k from the closed-form index decomposition.
  function automatic logic [31:0] model_addr(input logic [31:0] k, input logic [31:0] base,
      input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
      input logic [31:0] l0, input logic [31:0] l1, input logic [1:0] dim);
    logic [31:0] len0, len1, i0, i1, i2;
    if (dim == 2'b00) return base + k * s0;
    len0 = (l0 == 0) ? 32'd1 : l0;
    i0   = k % len0;
    if (dim != 2'b11) return base + i0 * s0 + (k / len0) * s1;
    len1 = (l1 == 0) ? 32'd1 : l1;
    i1   = (k / len0) % len1;
    i2   = k / (len0 * len1);
    return base + i0 * s0 + i1 * s1 + i2 * s2;
  endfunction

  // Runs one job against exp_q; called at a negedge with the DUT idle.
  task automatic run_job(input logic [31:0] base, input logic [31:0] s0, input logic [31:0] s1,
      input logic [31:0] s2, input logic [31:0] l0, input logic [31:0] l1, input logic [1:0] dim,
      input int stall, input bit poke_start);
    int k = 0;
    int cyc = 0;
    int tot = exp_q.size();
    check("ready_before_start", ready_start_o, 1);
    base_addr_i = base; tot_len_i = tot; d0_stride_i = s0; d1_stride_i = s1; d2_stride_i = s2;
    d0_len_i = l0; d1_len_i = l1; dim_enable_1h_i = dim; req_start_i = 1'b1;
    @(negedge clk_i);
    req_start_i = 1'b0;
    base_addr_i = $urandom; tot_len_i = $urandom; d0_stride_i = $urandom; d1_stride_i = $urandom;
    d2_stride_i = $urandom; d0_len_i = $urandom; d1_len_i = $urandom; dim_enable_1h_i = 2'($urandom);
    if (tot == 0) begin
      check("zero_len_done", done_o, 1);
      check("zero_len_valid", addr_valid_o, 0);
      @(negedge clk_i);
      check("zero_len_ready_after", ready_start_o, 1);
      check("zero_len_done_after", done_o, 0);
      return;
    end
    while (k < tot && cyc < 2000) begin
      check("run_valid", addr_valid_o, 1);
      check("run_addr", addr_o, exp_q[k]);
      check("run_no_done", done_o, 0);
      check("run_not_ready_start", ready_start_o, 0);
      addr_ready_i = ($urandom_range(99) >= stall);
      if (poke_start) req_start_i = 1'($urandom_range(1));
      if (addr_ready_i) k++;
      cyc++;
      @(negedge clk_i);
    end
    if (k < tot) begin
      errors++;
      $display("FAIL job_timeout: got %0d transfers expected %0d", k, tot);
    end
    addr_ready_i = 1'b0;
    req_start_i  = 1'b0;
    check("done_pulse", done_o, 1);
    check("done_valid_low", addr_valid_o, 0);
    check("done_ready_start_low", ready_start_o, 0);
    @(negedge clk_i);
    check("post_done_low", done_o, 0);
    check("post_done_ready_start", ready_start_o, 1);
    check("post_done_valid_low", addr_valid_o, 0);
  endtask

  initial begin
    vecs[0] = '{base: 32'h100, tot: 4, s0: 8, s1: 0, s2: 0, l0: 0, l1: 0, dim: 2'b00,
                exp: '{32'h100, 32'h108, 32'h110, 32'h118, 0, 0, 0, 0}};
    vecs[1] = '{base: 0, tot: 6, s0: 4, s1: 32'h40, s2: 0, l0: 3, l1: 0, dim: 2'b01,
                exp: '{0, 4, 8, 32'h40, 32'h44, 32'h48, 0, 0}};
    vecs[2] = '{base: 0, tot: 8, s0: 1, s1: 32'h10, s2: 32'h100, l0: 2, l1: 2, dim: 2'b11,
                exp: '{0, 1, 32'h10, 32'h11, 32'h100, 32'h101, 32'h110, 32'h111}};
    vecs[3] = '{base: 32'hFFFF_FFF8, tot: 2, s0: 8, s1: 0, s2: 0, l0: 0, l1: 0, dim: 2'b00,
                exp: '{32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0}};

    repeat (3) @(negedge clk_i);
    check("reset_ready_start", ready_start_o, 1);
    check("reset_done", done_o, 0);
    check("reset_valid", addr_valid_o, 0);
    check("reset_addr", addr_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) begin
      exp_q = {};
      for (int j = 0; j < int'(vecs[i].tot); j++) exp_q.push_back(vecs[i].exp[j]);
      run_job(vecs[i].base, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].l0, vecs[i].l1,
              vecs[i].dim, 0, 1'b0);
      @(negedge clk_i);
    end

    // Directed 2D vector again under heavy backpressure and start pokes.
    exp_q = {};
    for (int j = 0; j < 6; j++) exp_q.push_back(vecs[1].exp[j]);
    run_job(0, 4, 32'h40, 0, 3, 0, 2'b01, 60, 1'b1);
    @(negedge clk_i);

    exp_q = {};
    run_job(32'h1234, 4, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    @(negedge clk_i);

    // Clear at transfer 2 wins over a handshake and a start request in the same cycle.
    base_addr_i = 32'h200; tot_len_i = 5; d0_stride_i = 4; dim_enable_1h_i = 2'b00;
    req_start_i = 1'b1;
    @(negedge clk_i);
    req_start_i  = 1'b0;
    addr_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("clr_addr_before", addr_o, 32'h208);
    clear_i = 1'b1; req_start_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b0;
    check("clr_ready_start", ready_start_o, 1);
    check("clr_valid", addr_valid_o, 0);
    check("clr_addr_zero", addr_o, 0);
    for (int c = 0; c < 3; c++) begin
      check("clr_no_done", done_o, 0);
      @(negedge clk_i);
    end

    // Asynchronous reset mid-job aborts without a done pulse.
    base_addr_i = 32'h300; tot_len_i = 10; d0_stride_i = 4; req_start_i = 1'b1;
    @(negedge clk_i);
    req_start_i = 1'b0; addr_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", addr_valid_o, 0);
    check("arst_addr", addr_o, 0);
    check("arst_ready_start", ready_start_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1; addr_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("arst_no_done", done_o, 0);
      @(negedge clk_i);
    end

    for (int n = 0; n < 25; n++) begin
      logic [31:0] rb, r0, r1, r2, rl0, rl1;
      logic [1:0]  rd;
      int rtot;
      rb = $urandom; r0 = $urandom; r1 = $urandom; r2 = $urandom;
      rl0 = $urandom_range(4); rl1 = $urandom_range(4); rd = 2'($urandom_range(3));
      rtot = $urandom_range(20);
      exp_q = {};
      for (int k = 0; k < rtot; k++) exp_q.push_back(model_addr(k, rb, r0, r1, r2, rl0, rl1, rd));
      run_job(rb, r0, r1, r2, rl0, rl1, rd, 40, 1'b1);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
